// File: rtl/led_pkg.sv
// Shared types and defaults for the LED PWM output block.
// Mode encodings, loader states and small mode helpers.
package led_pkg;

  localparam int CH_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int SL_DEF = 32;

  typedef enum logic [1:0] {
    MODE_DIRECT     = 2'd0,
    MODE_DITHER     = 2'd1,
    MODE_SCRAMBLE   = 2'd2,
    MODE_DITHER_SCR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_READ,
    LD_LAST_CAPTURE,
    LD_DONE
  } ld_state_e;

  function automatic logic is_dither(input logic [1:0] m);
    return (m == MODE_DITHER) || (m == MODE_DITHER_SCR);
  endfunction

  function automatic logic is_scramble(input logic [1:0] m);
    return (m == MODE_SCRAMBLE) || (m == MODE_DITHER_SCR);
  endfunction

endpackage

// File: rtl/led_line_loader.sv
// Pixel line loader: issues CH reads for one scan line and
// tracks the one-cycle-late capture of the returned data.
module led_line_loader
  import led_pkg::*;
#(
  parameter int CH  = CH_DEF,
  parameter int SLW = 5,
  parameter int CW  = 4
) (
  input  logic               GCK,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SLW-1:0]     line,
  output logic               rd_en,
  output logic [SLW+CW-1:0]  rd_addr,
  output logic               cap_en,
  output logic [CW-1:0]      cap_col,
  output logic               done
);

  localparam logic [CW-1:0] LAST = CW'(CH - 1);

  ld_state_e      state, state_d;
  logic [CW-1:0]  col, col_d;
  logic [SLW-1:0] line_q;

  always_comb begin
    state_d = state;
    col_d   = col;
    unique case (state)
      LD_READ: begin
        if (col == LAST) state_d = LD_LAST_CAPTURE;
        else             col_d   = col + 1'b1;
      end
      LD_LAST_CAPTURE: state_d = LD_DONE;
      default: ;
    endcase
    if (abort) state_d = LD_IDLE;
    // a new line strobe always restarts from column 0
    if (start) begin
      state_d = LD_READ;
      col_d   = '0;
    end
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LD_IDLE;
      col     <= '0;
      line_q  <= '0;
      cap_en  <= 1'b0;
      cap_col <= '0;
    end else begin
      state   <= state_d;
      col     <= col_d;
      cap_en  <= rd_en;
      cap_col <= col;
      if (start) line_q <= line;
    end
  end

  assign rd_en   = (state == LD_READ);
  assign rd_addr = {line_q, col};
  assign done    = (state == LD_DONE);

endmodule

// File: rtl/led_pwm_out.sv
// LED column driver: double-buffered line registers, PWM
// comparators, Vsync edge handling and line/frame counters.
module led_pwm_out
  import led_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int SL = SL_DEF,
  localparam int SLW = $clog2(SL),
  localparam int CW  = $clog2(CH)
) (
  input  logic              GCK,
  input  logic              rst_n,
  input  logic              Vsync,
  input  logic [1:0]        mode,
  output logic              rd_en,
  output logic [SLW+CW-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic [CH-1:0]     OUT,
  output logic [SLW-1:0]    scan_line,
  output logic              load_err
);

  localparam logic [SLW-1:0] LAST_LINE = SLW'(SL - 1);

  logic           vs_q, rise, fall;
  logic           ld_fp, frame_phase;
  logic [1:0]     ld_mode, act_mode;
  logic [DW-1:0]  cnt, cmp, xf;
  logic [DW-1:0]  shadow [CH];
  logic [DW-1:0]  active [CH];
  logic [CH-1:0]  out_d;
  logic [SLW-1:0] next_line;
  logic           cap_en, done;
  logic [CW-1:0]  cap_col;

  assign rise      = Vsync & ~vs_q;
  assign fall      = ~Vsync & vs_q;
  assign next_line = (scan_line == LAST_LINE) ? '0 : scan_line + 1'b1;

  led_line_loader #(
    .CH  (CH),
    .SLW (SLW),
    .CW  (CW)
  ) u_loader (
    .GCK     (GCK),
    .rst_n   (rst_n),
    .start   (rise),
    .abort   (fall),
    .line    (next_line),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .cap_en  (cap_en),
    .cap_col (cap_col),
    .done    (done)
  );

  // halving plus phase-dependent rounding spreads the LSB over two frames
  always_comb begin
    xf = rd_data;
    if (is_dither(ld_mode))
      xf = (rd_data >> 1) + DW'(rd_data[0] & ~ld_fp);
  end

  always_comb begin
    cmp = cnt;
    if (is_scramble(act_mode))
      for (int i = 0; i < DW; i++) cmp[i] = cnt[DW-1-i];
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < CH; i++)
      out_d[i] = Vsync & vs_q & (active[i] > cmp);
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      cnt         <= '0;
      ld_mode     <= '0;
      ld_fp       <= 1'b0;
      act_mode    <= '0;
      scan_line   <= '0;
      frame_phase <= 1'b0;
      load_err    <= 1'b0;
      OUT         <= '0;
    end else begin
      vs_q <= Vsync;
      OUT  <= out_d;
      if (!vs_q)     cnt <= '0;
      else if (~&cnt) cnt <= cnt + 1'b1;
      if (rise) begin
        ld_mode <= mode;
        ld_fp   <= frame_phase;
      end
      if (fall) begin
        if (done) begin
          act_mode  <= ld_mode;
          scan_line <= next_line;
          if (scan_line == LAST_LINE) frame_phase <= ~frame_phase;
        end else begin
          load_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cap_en) shadow[cap_col] <= xf;
      if (fall && done)
        for (int i = 0; i < CH; i++) active[i] <= shadow[i];
    end
  end

endmodule
